imu_init_sequencer: RTL

Drives a table of register writes into the `i2c_setup` single-write I2C master so the IMU is configured after power-up without host involvement. It sits directly upstream of `i2c_setup`. For each table entry it presents `device_address`, `register_address` and `data_in`, handshakes on `start`/`done`, and then waits a programmable settling delay. It reports `init_done` to downstream readers, such as the accelerometer polling FSM, once the whole table has been written.

---
 rtl/imu_init_pkg.sv | 49 ++++
 rtl/imu_init_rom.sv | 26 ++
 rtl/imu_init_sequencer.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/imu_init_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | imu_init_pkg                                                       |
// | Shared types, entry layout and default IMU register write table.   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package imu_init_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_REQ   = 3'd2,
    S_WAIT  = 3'd3,
    S_POST  = 3'd4,
    S_NEXT  = 3'd5,
    S_DONE  = 3'd6,
    S_ERROR = 3'd7
  } state_t;

  localparam int ENTRY_W   = 24;
  localparam int FIELD_W   = 8;
  localparam int REG_LSB   = 16;
  localparam int DATA_LSB  = 8;
  localparam int DELAY_LSB = 0;
  localparam int MAX_CMDS  = 16;

  localparam logic [7:0] PWR_MGMT_1   = 8'h6B;
  localparam logic [7:0] ACCEL_CONFIG = 8'h1C;
  localparam logic [7:0] CONFIG       = 8'h1A;

  typedef logic [MAX_CMDS*ENTRY_W-1:0] table_t;

  function automatic logic [ENTRY_W-1:0] make_entry(input logic [7:0] reg_a,
                                                    input logic [7:0] data,
                                                    input logic [7:0] delay);
    return {reg_a, data, delay};
  endfunction

  // Entry 0 occupies the least significant slot.
  localparam table_t DEFAULT_TABLE = {
    {((MAX_CMDS-4)*ENTRY_W){1'b0}},
    make_entry(CONFIG,       8'h03, 8'd0),
    make_entry(ACCEL_CONFIG, 8'h00, 8'd0),
    make_entry(PWR_MGMT_1,   8'h01, 8'd10),
    make_entry(PWR_MGMT_1,   8'h80, 8'd100)
  };

endpackage
`default_nettype wire

// File: rtl/imu_init_rom.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | imu_init_rom                                                       |
// | Combinational index -> 24-bit {reg, data, delay} table lookup.     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module imu_init_rom
  import imu_init_pkg::*;
#(
  parameter table_t TABLE = DEFAULT_TABLE
) (
  input  logic [3:0]         i_index,
  output logic [ENTRY_W-1:0] o_entry
);

  always_comb begin
    o_entry = '0;
    for (int i = 0; i < MAX_CMDS; i++) begin
      if (i_index == 4'(i)) begin
        o_entry = TABLE[i*ENTRY_W +: ENTRY_W];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/imu_init_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | imu_init_sequencer                                                 |
// | Replays a register-write table into i2c_setup after power-up.      |
// | Optional watchdog: define SEQ_TIMEOUT_EN.                          |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module imu_init_sequencer
  import imu_init_pkg::*;
#(
  parameter int         NUM_CMDS       = 4,
  parameter logic [6:0] DEVICE_ADDR    = 7'h68,
  parameter int         DELAY_UNIT     = 25000,
  parameter int         TIMEOUT_CYCLES = 2_500_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       go,
  input  logic       i2c_done,
  output logic       i2c_start,
  output logic [6:0] device_address,
  output logic [7:0] register_address,
  output logic [7:0] data_out,
  output logic       busy,
  output logic       init_done,
  output logic       error,
  output logic [3:0] cmd_index
);

  localparam int               CNT_W  = $clog2(255*DELAY_UNIT+1);
  localparam logic [CNT_W-1:0] C_UNIT = CNT_W'(DELAY_UNIT);
  localparam logic [3:0]       C_LAST = 4'(NUM_CMDS-1);

  state_t             r_state;
  logic               r_done_meta;
  logic               r_done_sync;
  logic [CNT_W-1:0]   r_delay_cnt;
  logic [ENTRY_W-1:0] w_entry;

  assign device_address = DEVICE_ADDR;

  imu_init_rom u_rom (
    .i_index (cmd_index),
    .o_entry (w_entry)
  );

  // The writer idles with done high, so the synchronizer resets to 1 to
  // avoid a false acceptance on a go that closely follows reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_done_meta <= 1'b1;
      r_done_sync <= 1'b1;
    end else begin
      r_done_meta <= i2c_done;
      r_done_sync <= r_done_meta;
    end
  end

`ifdef SEQ_TIMEOUT_EN
  localparam int              WD_W      = $clog2(TIMEOUT_CYCLES+1);
  localparam logic [WD_W-1:0] C_WD_LAST = WD_W'(TIMEOUT_CYCLES-1);
  logic [WD_W-1:0] r_wdog;
  logic            r_error;
  assign error = r_error;
`else
  assign error = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state          <= S_IDLE;
      i2c_start        <= 1'b0;
      register_address <= '0;
      data_out         <= '0;
      busy             <= 1'b0;
      init_done        <= 1'b0;
      cmd_index        <= '0;
      r_delay_cnt      <= '0;
`ifdef SEQ_TIMEOUT_EN
      r_wdog           <= '0;
      r_error          <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (go) begin
            r_state   <= S_LOAD;
            busy      <= 1'b1;
            init_done <= 1'b0;
            cmd_index <= '0;
`ifdef SEQ_TIMEOUT_EN
            r_error   <= 1'b0;
`endif
          end
        end
        S_LOAD: begin
          register_address <= w_entry[REG_LSB +: FIELD_W];
          data_out         <= w_entry[DATA_LSB +: FIELD_W];
          r_delay_cnt      <= CNT_W'(w_entry[DELAY_LSB +: FIELD_W]) * C_UNIT;
          i2c_start        <= 1'b1;
          r_state          <= S_REQ;
`ifdef SEQ_TIMEOUT_EN
          r_wdog           <= '0;
`endif
        end
        S_REQ: begin
          if (!r_done_sync) begin
            i2c_start <= 1'b0;
            r_state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_done_sync) begin
            r_state <= S_POST;
          end
        end
        S_POST: begin
          if (r_delay_cnt == '0) begin
            r_state <= S_NEXT;
          end else begin
            r_delay_cnt <= r_delay_cnt - CNT_W'(1);
          end
        end
        S_NEXT: begin
          if (cmd_index == C_LAST) begin
            r_state   <= S_DONE;
            busy      <= 1'b0;
            init_done <= 1'b1;
          end else begin
            cmd_index <= cmd_index + 4'd1;
            r_state   <= S_LOAD;
          end
        end
        default: r_state <= S_IDLE;
      endcase
`ifdef SEQ_TIMEOUT_EN
      // Later assignments here override the handshake branch above.
      if (r_state == S_REQ || r_state == S_WAIT) begin
        if (r_wdog == C_WD_LAST) begin
          r_state   <= S_ERROR;
          r_error   <= 1'b1;
          busy      <= 1'b0;
          i2c_start <= 1'b0;
        end else begin
          r_wdog <= r_wdog + WD_W'(1);
        end
      end
`endif
    end
  end

endmodule
`default_nettype wire
